// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for a bit-serial compute-in-memory convolution.
// Walks every window origin of a square image, and for each window issues
// one CIM pass per activation bit (LSB first), then hands the result to the
// output function unit.
// Optional feature: define CONV_STALL_CNT_EN to enable the o_stall_cycles
// counter; without it o_stall_cycles is tied to zero.
module conv_seq_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int IMG_DIM        = 28,
  parameter int KERNEL_DIM     = 3,
  parameter int STRIDE         = 1,
  parameter int INPUT_CHANNELS = 2,
  parameter int XBAR_SIZE      = 128,
  parameter int BUS_WIDTH      = 16,
  localparam int WIN_ELEMS   = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM,
  localparam int V_CIM_TILES = (WIN_ELEMS + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int NUM_ADDR    = (WIN_ELEMS + BUS_WIDTH * V_CIM_TILES - 1) / (BUS_WIDTH * V_CIM_TILES),
  localparam int OUT_DIM     = (IMG_DIM - KERNEL_DIM) / STRIDE + 1,
  localparam int CNT_W       = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  localparam int ADDR_W      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
  localparam int POS_W       = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_ready,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic [POS_W-1:0]  o_row,
  output logic [POS_W-1:0]  o_col,
  output logic              o_cim_we,
  output logic              o_cim_start,
  input  logic              i_cim_ready,
  input  logic              i_func_ready,
  output logic              o_func_start,
  output logic [31:0]       o_stall_cycles
);

  localparam int LAST_POS = (OUT_DIM - 1) * STRIDE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT_CIM,
    WAIT_FUNC,
    HANDOFF
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic [POS_W-1:0]  row;
  logic [POS_W-1:0]  col;
  logic              first_wait;
  logic              done;

  logic last_addr;
  logic last_bit;
  logic last_col;
  logic last_win;

  assign last_addr = (addr == ADDR_W'(NUM_ADDR - 1));
  assign last_bit  = (count == CNT_W'(DATA_SIZE - 1));
  assign last_col  = (col == POS_W'(LAST_POS));
  assign last_win  = last_col && (row == POS_W'(LAST_POS));

  assign o_count = count;
  assign o_addr  = addr;
  assign o_row   = row;
  assign o_col   = col;
  assign o_done  = done;

  // State register; reset drops straight back to IDLE even mid-pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode and the per-state strobes.
  always_comb begin
    next_state   = state;
    o_ready      = 1'b0;
    o_cim_we     = 1'b0;
    o_cim_start  = 1'b0;
    o_func_start = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) next_state = LOAD;
      end
      LOAD: begin
        o_cim_we = 1'b1;
        if (last_addr) next_state = FIRE;
      end
      FIRE: begin
        o_cim_start = 1'b1;
        next_state  = WAIT_CIM;
      end
      WAIT_CIM: begin
        if (!first_wait && i_cim_ready) next_state = last_bit ? WAIT_FUNC : LOAD;
      end
      WAIT_FUNC: begin
        if (i_func_ready) next_state = HANDOFF;
      end
      HANDOFF: begin
        o_func_start = 1'b1;
        next_state   = last_win ? IDLE : LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit-slice, address and window-origin counters plus the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      addr       <= '0;
      row        <= '0;
      col        <= '0;
      first_wait <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == HANDOFF) && last_win;
      case (state)
        IDLE: begin
          if (i_start) begin
            count <= '0;
            addr  <= '0;
            row   <= '0;
            col   <= '0;
          end
        end
        LOAD: begin
          addr <= last_addr ? '0 : addr + 1'b1;
        end
        FIRE: begin
          addr       <= '0;
          first_wait <= 1'b1;
        end
        WAIT_CIM: begin
          first_wait <= 1'b0;
          if (!first_wait && i_cim_ready && !last_bit) count <= count + 1'b1;
        end
        HANDOFF: begin
          count <= '0;
          if (last_win) begin
            row <= '0;
            col <= '0;
          end else if (last_col) begin
            col <= '0;
            row <= row + POS_W'(STRIDE);
          end else begin
            col <= col + POS_W'(STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles spent waiting on the CIM or function unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && i_start) begin
      stall_cnt <= '0;
    end else if ((state == WAIT_CIM || state == WAIT_FUNC) && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cnt;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: randomized bench for conv_seq_ctrl with two instances.
// Unit 0: 5x5 image, 3x3 kernel, stride 1, 2 channels, 4-bit activations.
// Unit 1: 5x5 image, 3x3 kernel, stride 2, 1 channel, 1-bit activations.
module tb_conv_seq_ctrl;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  logic clk;
  logic rst;
  logic start_sig[2];
  logic cim_ready[2];
  logic func_ready[2];

  logic        rdy_a, done_a, we_a, cs_a, fs_a;
  logic [1:0]  cnt_a;
  logic [0:0]  addr_a;
  logic [2:0]  row_a, col_a;
  logic [31:0] stall_a;

  logic        rdy_b, done_b, we_b, cs_b, fs_b;
  logic [0:0]  cnt_b;
  logic [0:0]  addr_b;
  logic [2:0]  row_b, col_b;
  logic [31:0] stall_b;

  int n_total;
  int n_bad;
  int cyc;

  ev_t we_log[2][$];
  ev_t cs_log[2][$];
  ev_t fs_log[2][$];
  ev_t dn_log[2][$];
  int  f_used[2][$];
  int  viol[2];
  int  busy[2];
  int  pass_idx[2];
  int  k_cim[2];
  int  d_cur[2];
  int  k_fn[2];
  int  fn_lim[2];
  bit  fn_pend[2];
  int  cfg_dfix[2];
  int  cfg_ffirst[2];
  bit  cfg_frand[2];

  conv_seq_ctrl #(
    .DATA_SIZE(4), .IMG_DIM(5), .KERNEL_DIM(3), .STRIDE(1),
    .INPUT_CHANNELS(2), .XBAR_SIZE(128), .BUS_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .i_start(start_sig[0]), .o_ready(rdy_a), .o_done(done_a),
    .o_count(cnt_a), .o_addr(addr_a), .o_row(row_a), .o_col(col_a),
    .o_cim_we(we_a), .o_cim_start(cs_a), .i_cim_ready(cim_ready[0]),
    .i_func_ready(func_ready[0]), .o_func_start(fs_a), .o_stall_cycles(stall_a)
  );

  conv_seq_ctrl #(
    .DATA_SIZE(1), .IMG_DIM(5), .KERNEL_DIM(3), .STRIDE(2),
    .INPUT_CHANNELS(1), .XBAR_SIZE(128), .BUS_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst), .i_start(start_sig[1]), .o_ready(rdy_b), .o_done(done_b),
    .o_count(cnt_b), .o_addr(addr_b), .o_row(row_b), .o_col(col_b),
    .o_cim_we(we_b), .o_cim_start(cs_b), .i_cim_ready(cim_ready[1]),
    .i_func_ready(func_ready[1]), .o_func_start(fs_b), .o_stall_cycles(stall_b)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int ds_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int st_of(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic int od_of(input int u);
    return (5 - 3) / st_of(u) + 1;
  endfunction

  function automatic int na_of(input int u);
    int elems, tiles;
    elems = ((u == 0) ? 2 : 1) * 9;
    tiles = (elems + 127) / 128;
    return (elems + 16 * tiles - 1) / (16 * tiles);
  endfunction

  // Records one unit's outputs for this cycle and plays the CIM / func responders.
  task automatic observe(input int u, input bit rdy, input bit dn, input bit we, input bit cs,
                         input bit fs, input int cnt, input int adr, input int row, input int col);
    ev_t e;
    int  d, f;
    if (we) begin e = '{cyc, adr, 0, 0, 0}; we_log[u].push_back(e); end
    if (fs) begin e = '{cyc, row, col, 0, 0}; fs_log[u].push_back(e); end
    if (dn) begin e = '{cyc, int'(rdy), 0, 0, 0}; dn_log[u].push_back(e); end
    if ((int'(we) + int'(cs) + int'(fs) + int'(dn)) > 1) viol[u]++;
    if (rdy && (we || cs || fs)) viol[u]++;
    if (!rdy) busy[u]++;
    if (!rst) begin
      pass_idx[u]   = 0;
      fn_pend[u]    = 1'b0;
      k_cim[u]      = 0;
      d_cur[u]      = 1;
      cim_ready[u]  = 1'b0;
      func_ready[u] = 1'b1;
    end else if (cs) begin
      d = (cfg_dfix[u] != 0) ? cfg_dfix[u] : int'($urandom_range(1, 4));
      e = '{cyc, row, col, cnt, d};
      cs_log[u].push_back(e);
      d_cur[u]     = d;
      k_cim[u]     = 0;
      cim_ready[u] = 1'b0;
      if ((pass_idx[u] % ds_of(u)) == ds_of(u) - 1) begin
        if (pass_idx[u] / ds_of(u) == 0) f = cfg_ffirst[u];
        else f = cfg_frand[u] ? int'($urandom_range(0, 3)) : 0;
        f_used[u].push_back(f);
        fn_lim[u]     = ((d < 2) ? 2 : d) + 1 + f;
        k_fn[u]       = 0;
        fn_pend[u]    = 1'b1;
        func_ready[u] = 1'b0;
      end
      pass_idx[u]++;
    end else begin
      if (k_cim[u] < 1000) k_cim[u]++;
      cim_ready[u] = (k_cim[u] >= d_cur[u]);
      if (fn_pend[u]) begin
        k_fn[u]++;
        if (k_fn[u] >= fn_lim[u]) begin
          func_ready[u] = 1'b1;
          fn_pend[u]    = 1'b0;
        end
      end
    end
  endtask

  // Per-cycle observation of both units, away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    observe(0, rdy_a, done_a, we_a, cs_a, fs_a, int'(cnt_a), int'(addr_a), int'(row_a), int'(col_a));
    observe(1, rdy_b, done_b, we_b, cs_b, fs_b, int'(cnt_b), int'(addr_b), int'(row_b), int'(col_b));
  end

  task automatic clear_unit(input int u, input int dfix, input int ffirst, input bit frand);
    we_log[u].delete();
    cs_log[u].delete();
    fs_log[u].delete();
    dn_log[u].delete();
    f_used[u].delete();
    viol[u]       = 0;
    busy[u]       = 0;
    pass_idx[u]   = 0;
    cfg_dfix[u]   = dfix;
    cfg_ffirst[u] = ffirst;
    cfg_frand[u]  = frand;
  endtask

  // Runs one image on unit u and compares every event against a timeline built
  // from the pass/window rules and the responder delays that were chosen.
  task automatic test_full_image(input int u, input int dfix, input int ffirst, input bit frand,
                                 input bit pokes);
    int t0, guard, L, F, w, H, f, wi, ci, fi, stall_sum, exp_stall, act_stall;
    int od, ds, na, st, gc, ga, gb, gcn, d;
    od = od_of(u); ds = ds_of(u); na = na_of(u); st = st_of(u);
    clear_unit(u, dfix, ffirst, frand);
    t0 = cyc;
    start_sig[u] = 1'b1;
    @(negedge clk); #1;
    start_sig[u] = 1'b0;
    guard = 0;
    while (dn_log[u].size() == 0 && guard < 3000) begin
      if (pokes) start_sig[u] = (fs_log[u].size() < od * od) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk); #1;
      guard++;
    end
    start_sig[u] = 1'b0;
    n_total++;
    if (dn_log[u].size() == 0) begin
      n_bad++;
      $display("[TB] FAIL done_timeout unit=%0d: got no o_done after %0d cycles, required one", u, guard);
      return;
    end
    L = t0 + 1; wi = 0; ci = 0; fi = 0; stall_sum = 0; H = t0;
    for (int r = 0; r < od; r++) begin
      for (int c = 0; c < od; c++) begin
        for (int b = 0; b < ds; b++) begin
          for (int a = 0; a < na; a++) begin
            gc = (wi < we_log[u].size()) ? we_log[u][wi].cyc : -1;
            ga = (wi < we_log[u].size()) ? we_log[u][wi].a : -1;
            n_total++;
            if (gc !== L + a || ga !== a) begin
              n_bad++;
              $display("[TB] FAIL cim_we unit=%0d idx=%0d: got cyc=%0d addr=%0d, required cyc=%0d addr=%0d",
                       u, wi, gc, ga, L + a, a);
            end
            wi++;
          end
          F = L + na;
          gc  = (ci < cs_log[u].size()) ? cs_log[u][ci].cyc : -1;
          ga  = (ci < cs_log[u].size()) ? cs_log[u][ci].a : -1;
          gb  = (ci < cs_log[u].size()) ? cs_log[u][ci].b : -1;
          gcn = (ci < cs_log[u].size()) ? cs_log[u][ci].c : -1;
          d   = (ci < cs_log[u].size()) ? cs_log[u][ci].d : 2;
          n_total++;
          if (gc !== F || ga !== r * st || gb !== c * st || gcn !== b) begin
            n_bad++;
            $display("[TB] FAIL cim_start unit=%0d idx=%0d: got cyc=%0d row=%0d col=%0d count=%0d, required cyc=%0d row=%0d col=%0d count=%0d",
                     u, ci, gc, ga, gb, gcn, F, r * st, c * st, b);
          end
          ci++;
          w = (d < 2) ? 2 : d;
          stall_sum += w;
          if (b < ds - 1) begin
            L = F + w + 1;
          end else begin
            f = (fi < f_used[u].size()) ? f_used[u][fi] : 0;
            H = F + w + f + 2;
            gc = (fi < fs_log[u].size()) ? fs_log[u][fi].cyc : -1;
            ga = (fi < fs_log[u].size()) ? fs_log[u][fi].a : -1;
            gb = (fi < fs_log[u].size()) ? fs_log[u][fi].b : -1;
            n_total++;
            if (gc !== H || ga !== r * st || gb !== c * st) begin
              n_bad++;
              $display("[TB] FAIL func_start unit=%0d win=%0d: got cyc=%0d row=%0d col=%0d, required cyc=%0d row=%0d col=%0d",
                       u, fi, gc, ga, gb, H, r * st, c * st);
            end
            fi++;
            stall_sum += f + 1;
            L = H + 1;
          end
        end
      end
    end
    n_total++;
    if (we_log[u].size() !== wi || cs_log[u].size() !== ci || fs_log[u].size() !== fi) begin
      n_bad++;
      $display("[TB] FAIL pulse_totals unit=%0d: got we=%0d cs=%0d fs=%0d, required we=%0d cs=%0d fs=%0d",
               u, we_log[u].size(), cs_log[u].size(), fs_log[u].size(), wi, ci, fi);
    end
    n_total++;
    if (dn_log[u].size() !== 1 || dn_log[u][0].cyc !== H + 1 || dn_log[u][0].a !== 1) begin
      n_bad++;
      $display("[TB] FAIL done_pulse unit=%0d: got n=%0d cyc=%0d ready=%0d, required n=1 cyc=%0d ready=1",
               u, dn_log[u].size(), dn_log[u][0].cyc, dn_log[u][0].a, H + 1);
    end
    n_total++;
    if (busy[u] !== H - t0) begin
      n_bad++;
      $display("[TB] FAIL busy_cycles unit=%0d: got %0d not-ready cycles, required %0d", u, busy[u], H - t0);
    end
    n_total++;
    if (viol[u] !== 0) begin
      n_bad++;
      $display("[TB] FAIL pulse_exclusive unit=%0d: got %0d overlap cycles, required 0", u, viol[u]);
    end
`ifdef CONV_STALL_CNT_EN
    exp_stall = stall_sum;
`else
    exp_stall = 0;
`endif
    act_stall = (u == 0) ? int'(stall_a) : int'(stall_b);
    n_total++;
    if (act_stall !== exp_stall) begin
      n_bad++;
      $display("[TB] FAIL stall_cycles unit=%0d: got %0d, required %0d", u, act_stall, exp_stall);
    end
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({rdy_a, rdy_b} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL reset_ready: got %b, required 11", {rdy_a, rdy_b});
    end
    n_total++;
    if ({we_a, cs_a, fs_a, done_a, we_b, cs_b, fs_b, done_b} !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_pulses: got %b, required 00000000",
               {we_a, cs_a, fs_a, done_a, we_b, cs_b, fs_b, done_b});
    end
    n_total++;
    if ({cnt_a, addr_a, row_a, col_a, cnt_b, addr_b, row_b, col_b} !== 16'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_counters: got %h, required 0000",
               {cnt_a, addr_a, row_a, col_a, cnt_b, addr_b, row_b, col_b});
    end
    n_total++;
    if (stall_a !== 32'd0 || stall_b !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_stall: got %0d/%0d, required 0/0", stall_a, stall_b);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if ({we_a, cs_a, fs_a, done_a, we_b, cs_b, fs_b, done_b} !== 8'd0 || {rdy_a, rdy_b} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL post_reset_cycle: got pulses=%b ready=%b, required 00000000 / 11",
               {we_a, cs_a, fs_a, done_a, we_b, cs_b, fs_b, done_b}, {rdy_a, rdy_b});
    end
  endtask

  task automatic test_basic;
    $display("[TB] test_basic");
    test_full_image(0, 2, 0, 1'b0, 1'b0);
    n_total++;
    if (fs_log[0].size() !== 9 || cs_log[0].size() !== 36 || we_log[0].size() !== 72 || dn_log[0].size() !== 1) begin
      n_bad++;
      $display("[TB] FAIL basic_counts: got fs=%0d cs=%0d we=%0d done=%0d, required 9 36 72 1",
               fs_log[0].size(), cs_log[0].size(), we_log[0].size(), dn_log[0].size());
    end
`ifdef CONV_STALL_CNT_EN
    n_total++;
    if (stall_a !== 32'd81) begin
      n_bad++;
      $display("[TB] FAIL basic_stall: got %0d, required 81", stall_a);
    end
`endif
  endtask

  task automatic test_random_latency;
    $display("[TB] test_random_latency");
    for (int i = 0; i < 2; i++) test_full_image(0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_func_stall;
    $display("[TB] test_func_stall");
    test_full_image(0, 2, 10, 1'b0, 1'b0);
`ifdef CONV_STALL_CNT_EN
    n_total++;
    if (stall_a !== 32'd91) begin
      n_bad++;
      $display("[TB] FAIL func_stall_total: got %0d, required 91", stall_a);
    end
`endif
  endtask

  task automatic test_reset_midpass;
    int guard;
    $display("[TB] test_reset_midpass");
    clear_unit(0, 2, 0, 1'b0);
    start_sig[0] = 1'b1;
    @(negedge clk); #1;
    start_sig[0] = 1'b0;
    guard = 0;
    while (cs_log[0].size() < 9 && guard < 1000) begin
      @(negedge clk); #1;
      guard++;
    end
    n_total++;
    if (cs_log[0].size() < 9) begin
      n_bad++;
      $display("[TB] FAIL midpass_reach: got %0d cim_start pulses, required 9", cs_log[0].size());
    end
    @(negedge clk); #1;
    #1 rst = 1'b0;
    #1;
    n_total++;
    if (rdy_a !== 1'b1 || {we_a, cs_a, fs_a, done_a} !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL midpass_idle: got ready=%b pulses=%b, required 1 / 0000", rdy_a, {we_a, cs_a, fs_a, done_a});
    end
    n_total++;
    if ({cnt_a, addr_a, row_a, col_a} !== 9'd0 || stall_a !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL midpass_clear: got count=%0d addr=%0d row=%0d col=%0d stall=%0d, required all 0",
               cnt_a, addr_a, row_a, col_a, stall_a);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if ({we_a, cs_a, fs_a, done_a} !== 4'd0 || rdy_a !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midpass_release: got pulses=%b ready=%b, required 0000 / 1", {we_a, cs_a, fs_a, done_a}, rdy_a);
    end
    test_full_image(0, 0, 0, 1'b1, 1'b0);
    n_total++;
    if (cs_log[0].size() == 0 || cs_log[0][0].a !== 0 || cs_log[0][0].b !== 0 || cs_log[0][0].c !== 0) begin
      n_bad++;
      $display("[TB] FAIL restart_origin: got first pass at row=%0d col=%0d count=%0d, required 0 0 0",
               cs_log[0][0].a, cs_log[0][0].b, cs_log[0][0].c);
    end
  endtask

  task automatic test_stride2_single_bit;
    int exp_r[4];
    int exp_c[4];
    exp_r = '{0, 0, 2, 2};
    exp_c = '{0, 2, 0, 2};
    $display("[TB] test_stride2_single_bit");
    test_full_image(1, 0, 0, 1'b1, 1'b1);
    n_total++;
    if (fs_log[1].size() !== 4 || cs_log[1].size() !== 4 || we_log[1].size() !== 4) begin
      n_bad++;
      $display("[TB] FAIL stride2_counts: got fs=%0d cs=%0d we=%0d, required 4 4 4",
               fs_log[1].size(), cs_log[1].size(), we_log[1].size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < fs_log[1].size()) begin
        n_total++;
        if (fs_log[1][i].a !== exp_r[i] || fs_log[1][i].b !== exp_c[i]) begin
          n_bad++;
          $display("[TB] FAIL stride2_origin win=%0d: got (%0d,%0d), required (%0d,%0d)",
                   i, fs_log[1][i].a, fs_log[1][i].b, exp_r[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    $display("[TB] test_back_to_back");
    test_full_image(1, 0, 0, 1'b0, 1'b0);
    test_full_image(1, 1, 2, 1'b1, 1'b0);
  endtask

  // Test sequence.
  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst     = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_sig[u]  = 1'b0;
      cim_ready[u]  = 1'b0;
      func_ready[u] = 1'b1;
      clear_unit(u, 2, 0, 1'b0);
    end
    test_reset();
    @(negedge clk); #1;
    test_basic();
    test_random_latency();
    test_func_stall();
    test_reset_midpass();
    test_stride2_single_bit();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
